// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
// Merges ALU results (priority, never stalled) and load results (valid/ready,
// buffered in a small FIFO) onto the single write port of the register bank.
// Queued loads that are overtaken by a younger ALU write to the same register
// are squashed in place, and a pending mask tracks which registers still have
// a live queued write so issue logic can stall dependent reads.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Alu_Valid,
    input  logic [ADDR_WIDTH-1:0]         Alu_Register,
    input  logic [DATA_WIDTH-1:0]         Alu_Data,
    input  logic                          Mem_Valid,
    output logic                          Mem_Ready,
    input  logic [ADDR_WIDTH-1:0]         Mem_Register,
    input  logic [DATA_WIDTH-1:0]         Mem_Data,
    output logic [ADDR_WIDTH-1:0]         Write_Register,
    output logic [DATA_WIDTH-1:0]         Write_Data,
    output logic                          Reg_Write,
    output logic [31:0]                   Pending_Mask,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Queue storage: destination, data, and a live flag per slot. A slot's
    // live flag is only ever set while the slot is occupied, so it doubles
    // as "occupied and not squashed".
    logic [ADDR_WIDTH-1:0] slot_reg_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] slot_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q;
    logic [FIFO_DEPTH-1:0] live_d;

    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [31:0]           mask_q;
    logic [31:0]           mask_d;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_reg_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic                  alu_issue;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  head_live;

    // One-hot decode of a register index into the 32-bit pending mask.
    // Indices beyond bit 31 shift out and contribute nothing.
    function automatic logic [31:0] reg_onehot(input logic [ADDR_WIDTH-1:0] r);
        reg_onehot = 32'd1 << r;
    endfunction

    // Handshake and write-port selection for the current cycle.
    always_comb begin
        alu_issue  = Alu_Valid && (Alu_Register != '0);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        // No pass-through when full: a pop in the same cycle does not open
        // the door, which keeps Mem_Ready free of the selection logic.
        Mem_Ready  = rst_n && !fifo_full;
        // A load to r0 completes its handshake but never occupies a slot.
        push       = Mem_Valid && Mem_Ready && (Mem_Register != '0);
        // The ALU owns the port whenever it has a real write; an ALU write
        // to r0 is dropped and lets the queue drain instead.
        pop        = !alu_issue && !fifo_empty;
        head_live  = live_q[head_q];
    end

    // Next live flags: squash older matches first, then retire the head,
    // then append. The appended entry is younger than the ALU write of the
    // same cycle, so it is stored live even when the register matches.
    always_comb begin
        live_d = live_q;
        if (alu_issue) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (live_q[i] && (slot_reg_q[i] == Alu_Register)) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        if (push) begin
            live_d[tail_q] = 1'b1;
        end
    end

    // Next occupancy count; push and pop together leave it unchanged.
    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next pending mask, built from the post-edge queue contents so the
    // registered mask agrees with the queue on the same edge.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_d[i]) begin
                if (push && (PTR_W'(i) == tail_q)) begin
                    mask_d = mask_d | reg_onehot(Mem_Register);
                end else begin
                    mask_d = mask_d | reg_onehot(slot_reg_q[i]);
                end
            end
        end
        mask_d[0] = 1'b0;
    end

    // Queue control state: pointers, count, live flags and pending mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            mask_q  <= '0;
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
        end
    end

    // Queue payload; slots are qualified by live flags, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_reg_q[tail_q]  <= Mem_Register;
            slot_data_q[tail_q] <= Mem_Data;
        end
    end

    // Registered write port: ALU first, then the queue head, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else if (alu_issue) begin
            wr_en_q   <= 1'b1;
            wr_reg_q  <= Alu_Register;
            wr_data_q <= Alu_Data;
        end else if (pop) begin
            // A squashed head still retires, but produces no bank write.
            wr_en_q <= head_live;
            if (head_live) begin
                wr_reg_q  <= slot_reg_q[head_q];
                wr_data_q <= slot_data_q[head_q];
            end
        end else begin
            wr_en_q <= 1'b0;
        end
    end

    assign Reg_Write      = wr_en_q;
    assign Write_Register = wr_reg_q;
    assign Write_Data     = wr_data_q;
    assign Pending_Mask   = mask_q;
    assign Fifo_Count     = count_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Testbench for reg_writeback_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_reg_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Alu_Valid;
    logic [4:0]  Alu_Register;
    logic [31:0] Alu_Data;
    logic        Mem_Valid;
    logic        Mem_Ready;
    logic [4:0]  Mem_Register;
    logic [31:0] Mem_Data;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic        Reg_Write;
    logic [31:0] Pending_Mask;
    logic [2:0]  Fifo_Count;

    reg_writeback_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Alu_Valid(Alu_Valid),
        .Alu_Register(Alu_Register),
        .Alu_Data(Alu_Data),
        .Mem_Valid(Mem_Valid),
        .Mem_Ready(Mem_Ready),
        .Mem_Register(Mem_Register),
        .Mem_Data(Mem_Data),
        .Write_Register(Write_Register),
        .Write_Data(Write_Data),
        .Reg_Write(Reg_Write),
        .Pending_Mask(Pending_Mask),
        .Fifo_Count(Fifo_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rg;
        logic [31:0] data;
        logic        live;
    } ent_t;

    // Reference model state: queued loads in age order plus the expected
    // registered write port.
    ent_t        mq[$];
    logic        e_wr;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_known;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].rg] = 1'b1;
        return m;
    endfunction

    // One clock cycle: drive inputs, advance the model, compare outputs.
    task automatic step(input logic rn, input logic av, input logic [4:0] ar,
                        input logic [31:0] ad, input logic mv, input logic [4:0] mr,
                        input logic [31:0] md, output logic acc);
        logic rdy;
        ent_t e;
        rst_n = rn; Alu_Valid = av; Alu_Register = ar; Alu_Data = ad;
        Mem_Valid = mv; Mem_Register = mr; Mem_Data = md;
        #1;
        rdy = rn && (mq.size() < DEPTH);
        check_eq("mem_ready", Mem_Ready, rdy);
        acc = 1'b0;
        if (!rn) begin
            mq.delete();
            e_wr = 1'b0; e_reg = '0; e_data = '0; e_known = 1'b1;
        end else begin
            if (av && ar != 0) begin
                e_wr = 1'b1; e_reg = ar; e_data = ad; e_known = 1'b1;
                foreach (mq[i]) if (mq[i].rg == ar) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    e_wr = 1'b1; e_reg = e.rg; e_data = e.data; e_known = 1'b1;
                end else begin
                    e_wr = 1'b0; e_known = 1'b0;
                end
            end else begin
                e_wr = 1'b0;
            end
            if (mv && rdy) begin
                acc = 1'b1;
                if (mr != 0) begin
                    e.rg = mr; e.data = md; e.live = 1'b1;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("reg_write", Reg_Write, e_wr);
        if (e_known) begin
            check_eq("write_register", Write_Register, e_reg);
            check_eq("write_data", Write_Data, e_data);
        end
        check_eq("pending_mask", Pending_Mask, model_mask());
        check_eq("fifo_count", Fifo_Count, mq.size());
    endtask

    task automatic idle();
        logic a;
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
    endtask

    logic        acc;
    int          idx;
    logic [4:0]  mregs [6];
    logic [31:0] mdatas[6];

    initial begin
        e_wr = 0; e_reg = 0; e_data = 0; e_known = 1;

        // Reset
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
        step(1'b0, 1'b1, 5'd6, 32'h55, 1'b1, 5'd6, 32'h66, acc);
        check_eq("rst_reg_write", Reg_Write, 1'b0);
        check_eq("rst_count", Fifo_Count, 3'd0);
        check_eq("rst_mask", Pending_Mask, 32'd0);

        // Single ALU write
        step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, acc);
        check_eq("alu_wr", Reg_Write, 1'b1);
        check_eq("alu_reg", Write_Register, 5'd5);
        check_eq("alu_data", Write_Data, 32'h1234);
        idle();
        check_eq("alu_wr_off", Reg_Write, 1'b0);

        // Single load through the queue
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA, acc);
        check_eq("ld_mask7", Pending_Mask[7], 1'b1);
        check_eq("ld_count", Fifo_Count, 3'd1);
        check_eq("ld_no_bypass", Reg_Write, 1'b0);
        idle();
        check_eq("ld_wr", Reg_Write, 1'b1);
        check_eq("ld_reg", Write_Register, 5'd7);
        check_eq("ld_data", Write_Data, 32'hAAAA);
        check_eq("ld_mask_clr", Pending_Mask, 32'd0);

        // ALU starvation fills the queue, then drain in order
        for (int i = 0; i < 6; i++) begin
            mregs[i]  = 5'(10 + i);
            mdatas[i] = 32'hB000 + 32'(i);
        end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b1, 5'd3, 32'hC000 + 32'(c), 1'b1, mregs[idx], mdatas[idx], acc);
            if (acc) idx++;
        end
        check_eq("full_count", Fifo_Count, 3'd4);
        check_eq("full_ready", Mem_Ready, 1'b0);
        check_eq("full_accepted", 32'(idx), 32'd4);
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, (idx < 5), mregs[idx], mdatas[idx], acc);
            if (acc) idx++;
        end
        check_eq("fifth_accepted", 32'(idx), 32'd5);
        check_eq("drained", Fifo_Count, 3'd0);

        // Squash a queued load by a younger ALU write
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1111, acc);
        check_eq("sq_mask9_set", Pending_Mask[9], 1'b1);
        step(1'b1, 1'b1, 5'd9, 32'h2222, 1'b0, 5'd0, 32'd0, acc);
        check_eq("sq_mask9_clr", Pending_Mask[9], 1'b0);
        check_eq("sq_alu_data", Write_Data, 32'h2222);
        idle();
        check_eq("sq_pop_nowrite", Reg_Write, 1'b0);
        check_eq("sq_count", Fifo_Count, 3'd0);

        // Register-zero traffic on both producers
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, acc);
            check_eq("r0_handshake", acc, 1'b1);
            check_eq("r0_count", Fifo_Count, 3'd0);
            check_eq("r0_no_write", Reg_Write, 1'b0);
        end

        // Reset with entries queued
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 5'd1, 32'h10 + 32'(c), 1'b1, 5'(20 + c), 32'h70 + 32'(c), acc);
        end
        check_eq("pre_rst_count", Fifo_Count, 3'd3);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, acc);
        check_eq("mid_rst_count", Fifo_Count, 3'd0);
        check_eq("mid_rst_mask", Pending_Mask, 32'd0);
        check_eq("mid_rst_wr", Reg_Write, 1'b0);
        for (int c = 0; c < 4; c++) idle();

        // Random traffic; the memory unit holds its offer until accepted
        begin
            logic        hold_v;
            logic [4:0]  hold_r;
            logic [31:0] hold_d;
            logic        rn, av;
            hold_v = 1'b0; hold_r = '0; hold_d = '0;
            for (int c = 0; c < 3000; c++) begin
                rn = ($urandom_range(63) != 0);
                av = ($urandom_range(99) < 45);
                if (!hold_v && $urandom_range(99) < 60) begin
                    hold_v = 1'b1;
                    hold_r = 5'($urandom_range(7));
                    hold_d = $urandom;
                end
                step(rn, av, 5'($urandom_range(7)), $urandom, hold_v, hold_r, hold_d, acc);
                if (acc || !rn) hold_v = 1'b0;
            end
        end
        for (int c = 0; c < 8; c++) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Write-side companion of the MIPS core's 32x32 register bank.
- Merges results from two producers onto the bank's single write port (`Write_Register` / `Write_Data` / `Reg_Write`):
  - the single-cycle ALU, which has priority and cannot be stalled;
  - the load/memory unit, which uses a valid/ready handshake and is buffered in a small FIFO.
- Publishes a per-register pending mask so issue logic can stall reads of registers with queued writes.

Parameters:
- `DATA_WIDTH`, 32, width of result data.
- `ADDR_WIDTH`, 5, register index width.
- `FIFO_DEPTH`, 4, memory-result queue entries (power of two, ≥2).

Ports:
- `clk` input 1: clock; all state updates on posedge.
- `rst_n` input 1: synchronous active-low reset.
- `Alu_Valid` input 1: ALU result present this cycle.
- `Alu_Register` input `ADDR_WIDTH`: ALU destination register.
- `Alu_Data` input `DATA_WIDTH`: ALU result.
- `Mem_Valid` input 1: memory unit offers a load result.
- `Mem_Ready` output 1: arbiter accepts the memory result this cycle.
- `Mem_Register` input `ADDR_WIDTH`: load destination register.
- `Mem_Data` input `DATA_WIDTH`: load data.
- `Write_Register` output `ADDR_WIDTH`: to register bank.
- `Write_Data` output `DATA_WIDTH`: to register bank.
- `Reg_Write` output 1: to register bank, write enable.
- `Pending_Mask` output 32: bit i set while a live queued write targets register i.
- `Fifo_Count` output `clog2(FIFO_DEPTH)+1`: live plus squashed entries held.

Behaviour:
- Reset (`rst_n`=0 at posedge):
  - FIFO emptied; `Fifo_Count`=0; `Pending_Mask`=0.
  - `Reg_Write`=0, `Write_Register`=0, `Write_Data`=0.
  - Reset mid-operation discards all queued entries; no write issues after reset.
- `Mem_Ready` is combinational: `rst_n` AND NOT full. No full-with-pop pass-through: when `Fifo_Count`=`FIFO_DEPTH`, `Mem_Ready`=0 even if a pop occurs that cycle.
- Accept: `Mem_Valid` && `Mem_Ready` at posedge.
  - Register ≠ 0: push {reg, data, live=1}.
  - Register = 0: handshake completes, nothing enqueued.
- Write-port selection, evaluated each cycle; outputs registered, so there is 1-cycle latency from selection to `Reg_Write`:
  1. `Alu_Valid` and `Alu_Register`≠0: issue ALU write. FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop the head. A live head issues its write; a squashed head pops with `Reg_Write`=0 that cycle.
  3. Otherwise: `Reg_Write`=0; `Write_Register` and `Write_Data` hold their previous values.
- ALU result to register 0 is dropped and does not block the FIFO (rule 2 applies).
- Latency:
  - ALU input to `Reg_Write`: 1 cycle.
  - Memory result to `Reg_Write`: ≥2 cycles (push, then pop). There is no bypass around the FIFO.
- Ordering / squash:
  - ALU results are by construction younger than every queued memory result.
  - An issued ALU write to register R clears the live bit of every queued entry with reg=R, in the same cycle.
  - A memory result pushed in the same cycle as an ALU write to the same R is younger, so it is stored live and not squashed.
- `Pending_Mask`: OR over queued live entries of the one-hot of reg. Registered, updated the same edge as push/pop/squash. Bit 0 is always 0.
- Simultaneous push and pop (not full): count unchanged; the head advances and the tail appends.
- Pointers wrap modulo `FIFO_DEPTH`. `Fifo_Count` never exceeds `FIFO_DEPTH` and never underflows.
- ALU starvation of the FIFO is permitted. The FIFO fills, `Mem_Ready` drops, and the memory unit holds its data until ready.

Test Plan:
- Reset, then `Alu_Valid`=1, reg 5, data 0x1234 for one cycle → next cycle `Reg_Write`=1, `Write_Register`=5, `Write_Data`=0x1234; the following cycle `Reg_Write`=0.
- ALU idle, `Mem_Valid`=1, reg 7, data 0xAAAA for one cycle → `Pending_Mask`[7]=1 and `Fifo_Count`=1 after the push edge; write of 7/0xAAAA appears 2 cycles after acceptance; mask bit clears on pop.
- `Alu_Valid` held high to reg 3 while 5 memory results are offered → 4 accepted, `Mem_Ready`=0 with `Fifo_Count`=4. Drop `Alu_Valid` → writes drain in FIFO order over 4 cycles, and the fifth result is accepted when not full.
- Queue a memory write to reg 9 (0x1111), then issue ALU write to reg 9 (0x2222) before drain → `Pending_Mask`[9] clears and bank sees only 0x2222. The squashed pop cycle has `Reg_Write`=0.
- `Mem_Register`=0 and `Alu_Register`=0 with valids high → handshake completes, `Fifo_Count` stays 0, `Reg_Write` never asserts.
- 3 entries queued, assert `rst_n`=0 for one cycle → `Fifo_Count`=0, `Pending_Mask`=0, `Reg_Write`=0; no stale writes afterwards.
